// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared types and constants for the forwarding/hazard unit
package fwd_pkg;

  localparam int REG_AW          = 5;
  localparam int TAG_RD_W        = 8;  // widest register address a tag can hold
  localparam int FWD_SEL_REGFILE = 0;

  typedef struct packed {
    logic                valid;
    logic                regwrite;
    logic                is_load;
    logic [TAG_RD_W-1:0] rd;
  } fwd_tag_t;

endpackage

// File: rtl/fwd_src_match.sv
// rtl/fwd_src_match.sv - one EX source operand against the in-flight tag array
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int REG_AW    = fwd_pkg::REG_AW,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  fwd_tag_t [FWD_DEPTH-1:0] i_tags,
  input  logic [REG_AW-1:0]        i_rs,
  input  logic                     i_rs_used,
  input  logic                     i_valid,
  output logic [SEL_W-1:0]         o_sel,
  output logic                     o_not_ready
);

  logic [TAG_RD_W-1:0] w_rs;
  assign w_rs = TAG_RD_W'(i_rs);

  // Scan oldest to youngest so the youngest producer overwrites the result.
  always_comb begin
    o_sel       = SEL_W'(FWD_SEL_REGFILE);
    o_not_ready = 1'b0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (i_valid && i_rs_used && i_tags[k].valid && i_tags[k].regwrite &&
          (i_tags[k].rd != '0) && (i_tags[k].rd == w_rs)) begin
        o_sel       = SEL_W'(k + 1);
        o_not_ready = i_tags[k].is_load && (k < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX-stage forwarding selects, load-use stall and stall counter
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW    = fwd_pkg::REG_AW,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_W     = 32,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_ex_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_ex_rs,
  input  logic [NUM_SRC-1:0]        id_ex_rs_used,
  input  logic [REG_AW-1:0]         id_ex_rd,
  input  logic                      id_ex_regwrite,
  input  logic                      id_ex_is_load,
  input  logic                      flush,
  input  logic                      mem_busy,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall_id,
  output logic                      bubble_ex,
  output logic [CNT_W-1:0]          stall_cnt
);

  fwd_tag_t [FWD_DEPTH-1:0] r_tags;
  logic [NUM_SRC-1:0]       w_not_ready;
  logic                     w_hazard;
  logic [CNT_W-1:0]         r_cnt;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_src_match #(
      .REG_AW    (REG_AW),
      .FWD_DEPTH (FWD_DEPTH),
      .LOAD_LAT  (LOAD_LAT),
      .SEL_W     (SEL_W)
    ) u_match (
      .i_tags      (r_tags),
      .i_rs        (id_ex_rs[s*REG_AW +: REG_AW]),
      .i_rs_used   (id_ex_rs_used[s]),
      .i_valid     (id_ex_valid),
      .o_sel       (fwd_sel[s*SEL_W +: SEL_W]),
      .o_not_ready (w_not_ready[s])
    );
  end

  // A flushed instruction never consumes its operands, so it cannot stall.
  assign w_hazard  = !flush && (|w_not_ready);
  assign stall_id  = w_hazard || mem_busy;
  assign bubble_ex = w_hazard && !mem_busy;
  assign stall_cnt = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tags <= '0;
    end else if (!mem_busy) begin
      for (int k = FWD_DEPTH - 1; k > 0; k--) begin
        r_tags[k] <= r_tags[k-1];
      end
      if (id_ex_valid && !flush && !w_hazard) begin
        r_tags[0].valid    <= 1'b1;
        r_tags[0].regwrite <= id_ex_regwrite;
        r_tags[0].is_load  <= id_ex_is_load;
        r_tags[0].rd       <= TAG_RD_W'(id_ex_rd);
      end else begin
        r_tags[0] <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (bubble_ex && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Default-parameter instance
  logic        a_valid, a_rw, a_ld, a_flush, a_busy;
  logic [9:0]  a_rs;
  logic [1:0]  a_used;
  logic [4:0]  a_rd;
  logic [3:0]  a_sel;
  logic        a_stall, a_bubble;
  logic [31:0] a_cnt;

  fwd_hazard_unit u_a (
    .clk(clk), .rst_n(rst_n), .id_ex_valid(a_valid), .id_ex_rs(a_rs),
    .id_ex_rs_used(a_used), .id_ex_rd(a_rd), .id_ex_regwrite(a_rw),
    .id_ex_is_load(a_ld), .flush(a_flush), .mem_busy(a_busy),
    .fwd_sel(a_sel), .stall_id(a_stall), .bubble_ex(a_bubble), .stall_cnt(a_cnt)
  );

  // Deep pipe, three sources, 2-bit counter
  logic        b_valid, b_rw, b_ld, b_flush, b_busy;
  logic [14:0] b_rs;
  logic [2:0]  b_used;
  logic [4:0]  b_rd;
  logic [5:0]  b_sel;
  logic        b_stall, b_bubble;
  logic [1:0]  b_cnt;

  fwd_hazard_unit #(.NUM_SRC(3), .FWD_DEPTH(3), .LOAD_LAT(2), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .id_ex_valid(b_valid), .id_ex_rs(b_rs),
    .id_ex_rs_used(b_used), .id_ex_rd(b_rd), .id_ex_regwrite(b_rw),
    .id_ex_is_load(b_ld), .flush(b_flush), .mem_busy(b_busy),
    .fwd_sel(b_sel), .stall_id(b_stall), .bubble_ex(b_bubble), .stall_cnt(b_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [1:0] used, input logic [4:0] rd,
                       input logic rw, input logic ld);
    a_valid = v; a_rs = {rs2, rs1}; a_used = used; a_rd = rd; a_rw = rw; a_ld = ld;
    a_flush = 1'b0; a_busy = 1'b0;
    #1;
  endtask

  task automatic set_b(input logic v, input logic [4:0] rs3, input logic [2:0] used,
                       input logic [4:0] rd, input logic rw, input logic ld);
    b_valid = v; b_rs = {rs3, 10'd0}; b_used = used; b_rd = rd; b_rw = rw; b_ld = ld;
    b_flush = 1'b0; b_busy = 1'b0;
    #1;
  endtask

  task automatic clear_pipes();
    set_a(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    set_b(1'b0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 1'($urandom); a_rs = 10'($urandom); a_used = 2'($urandom);
    a_rd = 5'($urandom); a_rw = 1'($urandom); a_ld = 1'($urandom);
    a_flush = 1'($urandom); a_busy = 1'b0;
    set_b(1'b0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (a_sel !== 4'd0) begin n_err++; $display("FAIL reset_sel: got %0d want 0", a_sel); end
    n_cmp++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", a_stall); end
    n_cmp++; if (a_bubble !== 1'b0) begin n_err++; $display("FAIL reset_bubble: got %b want 0", a_bubble); end
    n_cmp++; if (a_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", a_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_pipes();
  endtask

  task automatic test_priority();
    set_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
    tick();
    set_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
    tick();
    set_a(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0);
    n_cmp++; if (a_sel[1:0] !== 2'd1) begin n_err++; $display("FAIL prio_young: got %0d want 1", a_sel[1:0]); end
    set_a(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    tick();
    set_a(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0);
    n_cmp++; if (a_sel[1:0] !== 2'd2) begin n_err++; $display("FAIL prio_old: got %0d want 2", a_sel[1:0]); end
    n_cmp++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL prio_nostall: got %b want 0", a_stall); end
    clear_pipes();
  endtask

  task automatic test_load_use();
    set_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
    tick();
    set_a(1'b1, 5'd0, 5'd7, 2'b10, 5'd8, 1'b1, 1'b0);
    n_cmp++; if (a_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b want 1", a_stall); end
    n_cmp++; if (a_bubble !== 1'b1) begin n_err++; $display("FAIL lu_bubble: got %b want 1", a_bubble); end
    tick();
    n_cmp++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL lu_release: got %b want 0", a_stall); end
    n_cmp++; if (a_sel[3:2] !== 2'd2) begin n_err++; $display("FAIL lu_sel: got %0d want 2", a_sel[3:2]); end
    n_cmp++; if (a_cnt !== 32'd1) begin n_err++; $display("FAIL lu_cnt: got %0d want 1", a_cnt); end
    clear_pipes();
  endtask

  task automatic test_x0_unused();
    set_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0);
    tick();
    set_a(1'b1, 5'd0, 5'd0, 2'b11, 5'd1, 1'b1, 1'b0);
    n_cmp++; if (a_sel !== 4'd0) begin n_err++; $display("FAIL x0_sel: got %0d want 0", a_sel); end
    set_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1);
    tick();
    set_a(1'b1, 5'd0, 5'd9, 2'b01, 5'd1, 1'b1, 1'b0);
    n_cmp++; if (a_sel[3:2] !== 2'd0) begin n_err++; $display("FAIL unused_sel: got %0d want 0", a_sel[3:2]); end
    n_cmp++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL unused_stall: got %b want 0", a_stall); end
    clear_pipes();
  endtask

  task automatic test_freeze_flush();
    set_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b1);
    tick();
    set_a(1'b1, 5'd4, 5'd0, 2'b01, 5'd2, 1'b1, 1'b0);
    a_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (a_stall !== 1'b1) begin n_err++; $display("FAIL frz_stall%0d: got %b want 1", i, a_stall); end
      n_cmp++; if (a_bubble !== 1'b0) begin n_err++; $display("FAIL frz_bubble%0d: got %b want 0", i, a_bubble); end
      tick();
    end
    n_cmp++; if (a_cnt !== 32'd1) begin n_err++; $display("FAIL frz_cnt: got %0d want 1", a_cnt); end
    a_busy = 1'b0;
    #1;
    n_cmp++; if (a_bubble !== 1'b1) begin n_err++; $display("FAIL frz_held: got %b want 1", a_bubble); end
    a_flush = 1'b1;
    #1;
    n_cmp++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b want 0", a_stall); end
    n_cmp++; if (a_bubble !== 1'b0) begin n_err++; $display("FAIL flush_bubble: got %b want 0", a_bubble); end
    tick();
    set_a(1'b1, 5'd4, 5'd0, 2'b01, 5'd2, 1'b1, 1'b0);
    n_cmp++; if (a_sel[1:0] !== 2'd2) begin n_err++; $display("FAIL flush_s0bub: got %0d want 2", a_sel[1:0]); end
    n_cmp++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL flush_after: got %b want 0", a_stall); end
    n_cmp++; if (a_cnt !== 32'd1) begin n_err++; $display("FAIL flush_cnt: got %0d want 1", a_cnt); end
    clear_pipes();
  endtask

  task automatic test_param_sweep();
    for (int r = 0; r < 3; r++) begin
      set_b(1'b1, 5'd0, 3'b000, 5'd10, 1'b1, 1'b1);
      tick();
      set_b(1'b1, 5'd10, 3'b100, 5'd11, 1'b1, 1'b0);
      for (int c = 0; c < 2; c++) begin
        n_cmp++; if (b_stall !== 1'b1) begin n_err++; $display("FAIL p_stall r%0d c%0d: got %b want 1", r, c, b_stall); end
        tick();
      end
      n_cmp++; if (b_stall !== 1'b0) begin n_err++; $display("FAIL p_release r%0d: got %b want 0", r, b_stall); end
      n_cmp++; if (b_sel[5:4] !== 2'd3) begin n_err++; $display("FAIL p_sel r%0d: got %0d want 3", r, b_sel[5:4]); end
      if (r == 0) begin
        n_cmp++; if (b_cnt !== 2'd2) begin n_err++; $display("FAIL p_cnt2: got %0d want 2", b_cnt); end
      end
      clear_pipes();
    end
    n_cmp++; if (b_cnt !== 2'd3) begin n_err++; $display("FAIL p_sat: got %0d want 3", b_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    set_a(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b1);
    tick();
    set_a(1'b1, 5'd3, 5'd0, 2'b01, 5'd2, 1'b1, 1'b0);
    n_cmp++; if (a_stall !== 1'b1) begin n_err++; $display("FAIL rms_pre: got %b want 1", a_stall); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL rms_stall: got %b want 0", a_stall); end
    n_cmp++; if (a_cnt !== 32'd0) begin n_err++; $display("FAIL rms_cnt: got %0d want 0", a_cnt); end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL rms_post: got %b want 0", a_stall); end
    n_cmp++; if (a_sel !== 4'd0) begin n_err++; $display("FAIL rms_sel: got %0d want 0", a_sel); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_load_use();
    test_x0_unused();
    test_freeze_flush();
    test_param_sweep();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
